audio_wave_writer: RTL and testbench

- Upstream producer for the SDRAM frame buffer / LCD path.
- Captures one screen-width of audio samples, then renders an 800x480 RGB565 oscilloscope frame and streams it pixel by pixel into the frame-buffer write FIFO (sys_we / sys_data_in).
- Pulses wr_load once per frame so the SDRAM write address restarts at 0, then repeats.

---
 rtl/audio_wave_pkg.sv | 18 +
 rtl/wave_line_buf.sv | 23 ++
 rtl/audio_wave_writer.sv | 164 ++++++++++++++++
 tb/tb_audio_wave_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_wave_pkg.sv
// Shared types, widths and colour constants for the audio oscilloscope writer.
package audio_wave_pkg;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAW    = 2'd2
  } state_t;

  localparam logic [15:0] C_TRACE  = 16'h07E0;
  localparam logic [15:0] C_CENTRE = 16'h7BEF;
  localparam logic [15:0] C_GRID   = 16'h39E7;
  localparam logic [15:0] C_BG     = 16'h0000;

endpackage

// File: rtl/wave_line_buf.sv
// One-line sample-row buffer: synchronous write, registered read (1-cycle latency).
module wave_line_buf #(
  parameter int unsigned DEPTH = 800,
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_wave_writer.sv
// Captures one line of audio samples, then streams an RGB565 oscilloscope frame
// into the frame-buffer write FIFO.
module audio_wave_writer
  import audio_wave_pkg::*;
#(
  parameter int unsigned H_PIX     = 800,
  parameter int unsigned V_PIX     = 480,
  parameter int unsigned AMP_SHIFT = 8,
  parameter int unsigned GRID_X    = 50,
  parameter int unsigned GRID_Y    = 48
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        sdram_init_done,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic        wr_ready,
  output logic        sys_we,
  output logic [15:0] sys_data_in,
  output logic        wr_load,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [X_W-1:0] X_LAST  = X_W'(H_PIX - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_PIX - 1);
  localparam logic [Y_W-1:0] Y_MID   = Y_W'(V_PIX / 2 - 1);
  localparam logic [X_W-1:0] GX_LAST = X_W'(GRID_X - 1);
  localparam logic [Y_W-1:0] GY_LAST = Y_W'(GRID_Y - 1);
  localparam logic signed [17:0] ROW_MID = 18'(V_PIX / 2 - 1);
  localparam logic signed [17:0] ROW_MAX = 18'(V_PIX - 1);

  state_t state, state_nxt;

  logic [X_W-1:0] cnt;
  logic [X_W-1:0] x, gx;
  logic [Y_W-1:0] y, gy;
  logic           scan_end;

  logic           cap_we, accept;
  logic [Y_W-1:0] cap_row, rd_row, last_row;

  logic           p1_valid, p1_x0, p1_gx0, p1_gy0, p1_last;
  logic [Y_W-1:0] p1_y;
  logic [15:0]    pix_colour;

  logic signed [15:0] shifted;
  logic signed [17:0] row_raw;

  always_ff @(posedge clk_ref) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!sdram_init_done) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = CAPTURE;
        CAPTURE: if (sample_valid && cnt == X_LAST) state_nxt = DRAW;
        DRAW:    if (frame_done) state_nxt = CAPTURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state == DRAW);
    cap_we = (state == CAPTURE) && sample_valid;
    accept = (state == DRAW) && wr_ready && !scan_end;
  end

  always_comb begin
    shifted = $signed(sample_data) >>> AMP_SHIFT;
    row_raw = ROW_MID - $signed({{2{shifted[15]}}, shifted});
    if (row_raw < 18'sd0)        cap_row = '0;
    else if (row_raw > ROW_MAX)  cap_row = Y_LAST;
    else                         cap_row = row_raw[Y_W-1:0];
  end

  wave_line_buf #(
    .DEPTH (H_PIX),
    .WIDTH (Y_W),
    .AW    (X_W)
  ) u_line_buf (
    .clk   (clk_ref),
    .we    (cap_we),
    .waddr (cnt),
    .wdata (cap_row),
    .re    (accept),
    .raddr (x),
    .rdata (rd_row)
  );

  // The RAM only reads on accept, so last_row is always the row of column x-1.
  always_comb begin
    logic [Y_W-1:0] r_prev, lo, hi;
    r_prev = p1_x0 ? rd_row : last_row;
    lo     = (r_prev < rd_row) ? r_prev : rd_row;
    hi     = (r_prev < rd_row) ? rd_row : r_prev;
    pix_colour = C_BG;
    if (p1_y >= lo && p1_y <= hi) pix_colour = C_TRACE;
    else if (p1_y == Y_MID)       pix_colour = C_CENTRE;
    else if (p1_gx0 || p1_gy0)    pix_colour = C_GRID;
  end

  always_ff @(posedge clk_ref) begin
    if (rst || !sdram_init_done) begin
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      gx          <= '0;
      gy          <= '0;
      scan_end    <= 1'b0;
      p1_valid    <= 1'b0;
      p1_x0       <= 1'b0;
      p1_gx0      <= 1'b0;
      p1_gy0      <= 1'b0;
      p1_last     <= 1'b0;
      p1_y        <= '0;
      last_row    <= '0;
      sys_we      <= 1'b0;
      sys_data_in <= '0;
      wr_load     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      wr_load     <= cap_we && (cnt == X_LAST);
      frame_done  <= p1_valid && p1_last;
      sys_we      <= p1_valid;
      sys_data_in <= p1_valid ? pix_colour : '0;
      p1_valid    <= accept;

      if (cap_we) cnt <= (cnt == X_LAST) ? '0 : cnt + 1'b1;
      if (p1_valid) last_row <= rd_row;
      if (state != DRAW) scan_end <= 1'b0;

      if (accept) begin
        p1_y    <= y;
        p1_x0   <= (x == '0);
        p1_gx0  <= (gx == '0);
        p1_gy0  <= (gy == '0);
        p1_last <= (x == X_LAST) && (y == Y_LAST);
        if (x == X_LAST) begin
          x  <= '0;
          gx <= '0;
          if (y == Y_LAST) begin
            y        <= '0;
            gy       <= '0;
            scan_end <= 1'b1;
          end else begin
            y  <= y + 1'b1;
            gy <= (gy == GY_LAST) ? '0 : gy + 1'b1;
          end
        end else begin
          x  <= x + 1'b1;
          gx <= (gx == GX_LAST) ? '0 : gx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_wave_writer.sv
// Scoreboard bench for audio_wave_writer on a reduced frame geometry.
module tb_audio_wave_writer;
  import audio_wave_pkg::*;

  localparam int H  = 40;
  localparam int V  = 24;
  localparam int GX = 10;
  localparam int GY = 8;
  localparam int SH = 8;
  localparam int BUDGET = H * V * 4 + 200;

  logic        clk_ref = 1'b0;
  logic        rst, sdram_init_done, sample_valid, wr_ready;
  logic [15:0] sample_data;
  logic        sys_we, wr_load, frame_done, busy;
  logic [15:0] sys_data_in;

  audio_wave_writer #(
    .H_PIX     (H),
    .V_PIX     (V),
    .AMP_SHIFT (SH),
    .GRID_X    (GX),
    .GRID_Y    (GY)
  ) dut (
    .clk_ref         (clk_ref),
    .rst             (rst),
    .sdram_init_done (sdram_init_done),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .wr_ready        (wr_ready),
    .sys_we          (sys_we),
    .sys_data_in     (sys_data_in),
    .wr_load         (wr_load),
    .frame_done      (frame_done),
    .busy            (busy)
  );

  always #5 clk_ref = ~clk_ref;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] fb [V][H];
  logic [15:0] samples [H];
  int rows [H];
  int fd_cnt = 0, wl_cnt = 0, we_cnt = 0, pix_idx = 0, cyc = 0, wl_cyc = 0;
  bit wl_armed = 1'b0;
  bit bp_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_row(input logic [15:0] s);
    int v, r;
    v = int'($signed(s));
    r = (V / 2 - 1) - (v >>> SH);
    if (r < 0) r = 0;
    if (r > V - 1) r = V - 1;
    return r;
  endfunction

  function automatic logic [15:0] model_pix(input int x, input int y);
    int rc, rp, lo, hi;
    rc = rows[x];
    rp = (x == 0) ? rc : rows[x - 1];
    lo = (rp < rc) ? rp : rc;
    hi = (rp < rc) ? rc : rp;
    if (y >= lo && y <= hi) return 16'h07E0;
    if (y == V / 2 - 1)     return 16'h7BEF;
    if (x % GX == 0 || y % GY == 0) return 16'h39E7;
    return 16'h0000;
  endfunction

  task automatic build_frame();
    for (int x = 0; x < H; x++) rows[x] = model_row(samples[x]);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back(model_pix(x, y));
  endtask

  always @(negedge clk_ref) begin
    cyc++;
    if (rst || !sdram_init_done) pix_idx = 0;
    if (wr_load) begin
      wl_cnt++;
      wl_cyc = cyc;
      wl_armed = 1'b1;
    end
    if (sys_we) begin
      if (wl_armed) begin
        check_eq("wl_lead", 32'(cyc - wl_cyc >= 2), 1);
        wl_armed = 1'b0;
      end
      check_eq("we_in_draw", busy, 1);
      check_eq("queue_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("pix", sys_data_in, exp_q.pop_front());
      if (pix_idx < H * V) fb[pix_idx / H][pix_idx % H] = sys_data_in;
      pix_idx++;
      we_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      check_eq("fd_with_last_we", sys_we, 1);
      check_eq("frame_pix_count", pix_idx, H * V);
      pix_idx = 0;
    end
  end

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk_ref);
      #1;
      wr_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic capture_frame(input bit gaps);
    int wl0;
    wl0 = wl_cnt;
    check_eq("cap_not_busy", busy, 0);
    for (int i = 0; i < H; i++) begin
      if (i == H - 1) check_eq("no_early_wl", wl_cnt, wl0);
      sample_valid = 1'b1;
      sample_data  = samples[i];
      tick();
      if (gaps && (i % 7 == 3)) begin
        sample_valid = 1'b0;
        tick();
      end
    end
    sample_valid = 1'b0;
    build_frame();
    tick();
    tick();
    check_eq("wl_pulse", wl_cnt, wl0 + 1);
  endtask

  task automatic wait_frame();
    int fd0;
    fd0 = fd_cnt;
    for (int n = 0; n < BUDGET && fd_cnt == fd0; n++) tick();
    check_eq("frame_done_seen", fd_cnt, fd0 + 1);
    tick();
    check_eq("single_frame_done", fd_cnt, fd0 + 1);
    check_eq("q_drained", exp_q.size(), 0);
    check_eq("busy_after_frame", busy, 0);
  endtask

  task automatic random_samples();
    for (int i = 0; i < H; i++) samples[i] = 16'($urandom);
  endtask

  initial begin
    int fd0, we0;
    rst = 1'b1;
    sdram_init_done = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reset_outs", {sys_we, wr_load, frame_done, busy, sys_data_in}, 0);
    end
    rst = 1'b0;
    tick();
    tick();
    check_eq("post_reset_busy", busy, 0);
    check_eq("post_reset_wl", wl_cnt, 0);

    // zero input
    for (int i = 0; i < H; i++) samples[i] = 16'h0000;
    capture_frame(1'b0);
    wait_frame();
    check_eq("centre_trace_x0",  fb[V/2-1][0],     16'h07E0);
    check_eq("centre_trace_mid", fb[V/2-1][H/2],   16'h07E0);
    check_eq("centre_trace_end", fb[V/2-1][H-1],   16'h07E0);
    check_eq("bg_1_1",           fb[1][1],         16'h0000);
    check_eq("grid_gx_1",        fb[1][GX],        16'h39E7);

    // clamp and fill
    for (int i = 0; i < H; i++) samples[i] = 16'h0000;
    samples[0] = 16'h7FFF;
    samples[1] = 16'h8000;
    capture_frame(1'b0);
    wait_frame();
    for (int y = 0; y < V; y++) check_eq("col1_fill", fb[y][1], 16'h07E0);
    check_eq("col0_top",    fb[0][0],     16'h07E0);
    check_eq("col0_y1",     fb[1][0],     16'h39E7);
    check_eq("col0_centre", fb[V/2-1][0], 16'h7BEF);
    check_eq("col0_bottom", fb[V-1][0],   16'h39E7);

    // random samples with backpressure and capture gaps
    random_samples();
    capture_frame(1'b1);
    bp_en = 1'b1;
    wait_frame();
    bp_en = 1'b0;

    // samples presented during DRAW are dropped
    random_samples();
    capture_frame(1'b0);
    repeat (150) tick();
    check_eq("drop_busy", busy, 1);
    sample_valid = 1'b1;
    sample_data  = 16'h1234;
    repeat (4) tick();
    sample_valid = 1'b0;
    wait_frame();
    random_samples();
    capture_frame(1'b0);
    wait_frame();

    // abort mid-frame by dropping sdram_init_done
    random_samples();
    capture_frame(1'b0);
    for (int n = 0; n < BUDGET && pix_idx < 300; n++) tick();
    check_eq("abort_reach", 32'(pix_idx >= 300), 1);
    sdram_init_done = 1'b0;
    tick();
    check_eq("abort_we_off", sys_we, 0);
    exp_q.delete();
    fd0 = fd_cnt;
    we0 = we_cnt;
    repeat (20) tick();
    check_eq("abort_no_fd", fd_cnt, fd0);
    check_eq("abort_no_we", we_cnt, we0);
    check_eq("abort_idle", busy, 0);
    sdram_init_done = 1'b1;
    tick();
    tick();
    random_samples();
    capture_frame(1'b1);
    wait_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
